dram_generate_instruction: RTL and testbench
============================================

// Module: dram_generate_instruction
// PURPOSE
//  FCFS DRAM command generator for one DDR4-style rank of 16 banks (4 BG x 4 banks).
//  Takes the request at the head of an upstream request FIFO and emits one PRE/ACT/RD/WR
//  per cycle, tracking per-bank open rows and timing counters.
//  Pops the FIFO head when the request's column command issues.
//  Sits between the request FIFO and the DRAM PHY command encoder.
// PARAMETERS
//  T_RCD   14  ACT->RD/WR same bank (cycles)
//  T_RP    14  PRE->ACT same bank
//  T_RAS   32  ACT->PRE same bank
//  T_RTP    8  RD->PRE same bank
//  T_WR    16  write recovery, counted after the end of write data
//  CWL     12  write latency
//  BURST    4  data-bus cycles per burst (BL8)
//  T_CCD_L  6  RD/WR->RD/WR, same BG
//  T_CCD_S  4  RD/WR->RD/WR, different BG
//  T_RRD_L  6  ACT->ACT, same BG
//  T_RRD_S  4  ACT->ACT, different BG
//  T_WTR    6  end of write data -> RD, any bank
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  address     in   32  head request: [29:16] row, [15:14] BG, [13:12] bank, [11:4] col; [31:30],[3:0] ignored
//  r_w         in   1   0 = read, 1 = write
//  write_data  in   32  write payload (not used by command logic)
//  fifo_empty  in   1   1 = no valid head request
//  pop         out  1   consume head request this cycle
//  command     out  3   NOP=0, PRE=1, ACT=2, RD=3, WR=4
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high.
//  - command and pop are combinational from registered state plus current inputs.
//    A command "issues" at the rising edge where it is non-NOP; state updates at that edge.
//  - While reset=1: command=NOP, pop=0. At the reset edge all banks close and all counters clear.
//  - State per bank b={BG,bank}: open, open_row[13:0], counters t_can_act/pre/rd/wr.
//  - Counter rules:
//    - A command is legal when its counter is 0.
//    - Each counter decrements by 1 per cycle and saturates at 0.
//    - On a constraint, load max(current, T-1), so the dependent command is legal exactly T cycles later.
//  - Decision each cycle, only when fifo_empty=0, for target bank b:
//    - b open, row match: issue RD (r_w=0) when t_can_rd[b]==0, or WR (r_w=1) when t_can_wr[b]==0.
//      pop=1 in that same cycle.
//    - b open, row mismatch: issue PRE when t_can_pre[b]==0.
//    - b closed: issue ACT when t_can_act[b]==0.
//    - Otherwise: NOP.
//    - pop is never asserted with PRE, ACT or NOP.
//  - When fifo_empty=1: command=NOP, pop=0. Counters keep running.
//  - Counter updates on each issued command:
//    - ACT b: open=1, open_row=row. rd/wr[b] <- T_RCD; pre[b] <- T_RAS.
//      act of other banks <- T_RRD_L (same BG) or T_RRD_S (other BG).
//    - RD b: pre[b] <- T_RTP. rd/wr of all banks <- T_CCD_L (same BG) or T_CCD_S (other BG).
//    - WR b: pre[b] <- CWL+BURST+T_WR. rd/wr of all banks <- T_CCD_L or T_CCD_S.
//      rd of all banks <- CWL+BURST+T_WTR.
//    - PRE b: open=0; act[b] <- T_RP.
//  - Strict FCFS: no reordering and no speculative commands to other banks.
//  - Rows stay open after access (open-page policy).
//  - Head changes between cycles are allowed; each decision is re-evaluated on the current address.
//  - Mid-operation reset: outputs go to NOP/0 that cycle; all state is lost; the head is not popped.
//  - Bank state is readable hierarchically as bank_info[i].t_can_rd/.t_can_wr/.t_can_pre (i=0..15).
// TESTING
//  - Reset: hold reset 10 cycles with fifo_empty=0 -> command=NOP and pop=0 every cycle.
//  - Row hits: BG0 B0 row 0x200 reads at col 0x00, 0x08, 0x10.
//    -> ACT@0, RD@14 with pop; each later RD >=6 cycles after the previous one; no further ACT or PRE.
//  - Row conflict: BG0 B0 row 0xA, then row 0xB.
//    -> ACT@0, RD@14, PRE@32 (T_RAS bound), ACT@46, RD@60.
//  - Multi-bank: BG0B0 r0x64, BG0B1 r0xC8, BG0B0 r0x64 col8, BG1B0 r0x12C.
//    -> the second ACT is >=6 cycles after the first; the third request issues RD with no ACT;
//       the BG1 ACT is spaced >=4 cycles from the previous ACT.
//  - Write then read same bank: WR then RD to the same row.
//    -> RD no earlier than WR+22 (CWL+BURST+T_WTR).
//    Then a PRE to that bank no earlier than WR+32.
//  - Ping-pong rows 0xA/0xB on BG0B0, 4 reads.
//    -> every request after the first issues the sequence PRE, ACT, RD.
//    -> exactly 4 pops in total.

Source files
------------

// File: rtl/dram_generate_instruction.sv
// rtl/dram_generate_instruction.sv - FCFS PRE/ACT/RD/WR command generator for one 16-bank DDR4-style rank
module dram_generate_instruction #(
    parameter int T_RCD   = 14,
    parameter int T_RP    = 14,
    parameter int T_RAS   = 32,
    parameter int T_RTP   = 8,
    parameter int T_WR    = 16,
    parameter int CWL     = 12,
    parameter int BURST   = 4,
    parameter int T_CCD_L = 6,
    parameter int T_CCD_S = 4,
    parameter int T_RRD_L = 6,
    parameter int T_RRD_S = 4,
    parameter int T_WTR   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        r_w,
    input  logic [31:0] write_data,
    input  logic        fifo_empty,
    output logic        pop,
    output logic [2:0]  command
);

    localparam int CW = 7;
    typedef logic [CW-1:0] cnt_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_PRE = 3'd1;
    localparam logic [2:0] CMD_ACT = 3'd2;
    localparam logic [2:0] CMD_RD  = 3'd3;
    localparam logic [2:0] CMD_WR  = 3'd4;

    // Each load value is T-1: the dependent command becomes legal exactly T cycles after issue.
    localparam cnt_t LD_RCD    = cnt_t'(T_RCD - 1);
    localparam cnt_t LD_RP     = cnt_t'(T_RP - 1);
    localparam cnt_t LD_RAS    = cnt_t'(T_RAS - 1);
    localparam cnt_t LD_RTP    = cnt_t'(T_RTP - 1);
    localparam cnt_t LD_WR_PRE = cnt_t'(CWL + BURST + T_WR - 1);
    localparam cnt_t LD_WTR    = cnt_t'(CWL + BURST + T_WTR - 1);
    localparam cnt_t LD_CCD_L  = cnt_t'(T_CCD_L - 1);
    localparam cnt_t LD_CCD_S  = cnt_t'(T_CCD_S - 1);
    localparam cnt_t LD_RRD_L  = cnt_t'(T_RRD_L - 1);
    localparam cnt_t LD_RRD_S  = cnt_t'(T_RRD_S - 1);

    // Saturating one-per-cycle decrement.
    function automatic cnt_t dec_sat(input cnt_t c);
        return (c == '0) ? '0 : c - cnt_t'(1);
    endfunction

    // New constraint never shortens an existing, stricter one.
    function automatic cnt_t load_max(input cnt_t c, input cnt_t t);
        cnt_t d;
        d = dec_sat(c);
        return (d > t) ? d : t;
    endfunction

    function automatic cnt_t cmax(input cnt_t a, input cnt_t b);
        return (a > b) ? a : b;
    endfunction

    // Head request decode
    logic [3:0]  tgt_bank;
    logic [1:0]  tgt_bg;
    logic [13:0] tgt_row;

    assign tgt_bank = address[15:12];
    assign tgt_bg   = address[15:14];
    assign tgt_row  = address[29:16];

    // Payload and column bits do not affect command selection.
    logic unused_bits;
    assign unused_bits = ^{write_data, address[31:30], address[11:0]};

    // Flattened views of per-bank state for the decision mux
    logic [15:0] open_vec;
    logic [13:0] row_vec [16];
    cnt_t        act_vec [16];
    cnt_t        pre_vec [16];
    cnt_t        rd_vec  [16];
    cnt_t        wr_vec  [16];

    logic [2:0]  cmd_c;
    logic        pop_c;

    // Strict FCFS decision for the head request only; pop only with its column command.
    always_comb begin
        cmd_c = CMD_NOP;
        pop_c = 1'b0;
        if (!reset && !fifo_empty) begin
            if (open_vec[tgt_bank]) begin
                if (row_vec[tgt_bank] == tgt_row) begin
                    if (!r_w && rd_vec[tgt_bank] == '0) begin
                        cmd_c = CMD_RD;
                        pop_c = 1'b1;
                    end else if (r_w && wr_vec[tgt_bank] == '0) begin
                        cmd_c = CMD_WR;
                        pop_c = 1'b1;
                    end
                end else if (pre_vec[tgt_bank] == '0) begin
                    cmd_c = CMD_PRE;
                end
            end else if (act_vec[tgt_bank] == '0) begin
                cmd_c = CMD_ACT;
            end
        end
    end

    assign command = cmd_c;
    assign pop     = pop_c;

    // Column-to-column spacing depends on whether the bank shares the target's bank group.
    for (genvar i = 0; i < 16; i++) begin : bank_info
        localparam logic [3:0] IDX = 4'(i);

        logic        open_q;
        logic [13:0] open_row_q;
        cnt_t        t_can_act;
        cnt_t        t_can_pre;
        cnt_t        t_can_rd;
        cnt_t        t_can_wr;

        logic        hit;
        logic        same_bg;
        cnt_t        ccd_ld;
        cnt_t        rrd_ld;

        assign hit     = (tgt_bank == IDX);
        assign same_bg = (tgt_bg == IDX[3:2]);
        assign ccd_ld  = same_bg ? LD_CCD_L : LD_CCD_S;
        assign rrd_ld  = same_bg ? LD_RRD_L : LD_RRD_S;

        // Per-bank open-row tracking and timing counters, updated on each issued command.
        always_ff @(posedge clk) begin
            if (reset) begin
                open_q     <= 1'b0;
                open_row_q <= '0;
                t_can_act  <= '0;
                t_can_pre  <= '0;
                t_can_rd   <= '0;
                t_can_wr   <= '0;
            end else begin
                t_can_act <= dec_sat(t_can_act);
                t_can_pre <= dec_sat(t_can_pre);
                t_can_rd  <= dec_sat(t_can_rd);
                t_can_wr  <= dec_sat(t_can_wr);
                case (cmd_c)
                    CMD_ACT: begin
                        if (hit) begin
                            open_q     <= 1'b1;
                            open_row_q <= tgt_row;
                            t_can_rd   <= load_max(t_can_rd, LD_RCD);
                            t_can_wr   <= load_max(t_can_wr, LD_RCD);
                            t_can_pre  <= load_max(t_can_pre, LD_RAS);
                        end else begin
                            t_can_act  <= load_max(t_can_act, rrd_ld);
                        end
                    end
                    CMD_RD: begin
                        if (hit) begin
                            t_can_pre <= load_max(t_can_pre, LD_RTP);
                        end
                        t_can_rd <= load_max(t_can_rd, ccd_ld);
                        t_can_wr <= load_max(t_can_wr, ccd_ld);
                    end
                    CMD_WR: begin
                        if (hit) begin
                            t_can_pre <= load_max(t_can_pre, LD_WR_PRE);
                        end
                        t_can_rd <= load_max(t_can_rd, cmax(ccd_ld, LD_WTR));
                        t_can_wr <= load_max(t_can_wr, ccd_ld);
                    end
                    CMD_PRE: begin
                        if (hit) begin
                            open_q    <= 1'b0;
                            t_can_act <= load_max(t_can_act, LD_RP);
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign open_vec[i] = open_q;
        assign row_vec[i]  = open_row_q;
        assign act_vec[i]  = t_can_act;
        assign pre_vec[i]  = t_can_pre;
        assign rd_vec[i]   = t_can_rd;
        assign wr_vec[i]   = t_can_wr;
    end

endmodule

// File: tb/tb_dram_generate_instruction.sv
// tb/tb_dram_generate_instruction.sv - directed self-checking bench for dram_generate_instruction
module tb_dram_generate_instruction;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic        r_w = 1'b0;
    logic [31:0] write_data = '0;
    logic        fifo_empty = 1'b1;
    logic        pop;
    logic [2:0]  command;

    always #5 clk = ~clk;

    dram_generate_instruction dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .r_w        (r_w),
        .write_data (write_data),
        .fifo_empty (fifo_empty),
        .pop        (pop),
        .command    (command)
    );

    localparam int NOP = 0, PRE = 1, ACT = 2, RD = 3, WR = 4;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] req_q [$];
    int ev_cmd [$];
    int ev_cyc [$];
    int ev_pop [$];
    int exp_cmd [$];
    int exp_cyc [$];
    int n_pops;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] mk(input int bg, input int bk, input int row, input int col, input bit rw);
        logic [31:0] a;
        a = '0;
        a[29:16] = 14'(row);
        a[15:14] = 2'(bg);
        a[13:12] = 2'(bk);
        a[11:4]  = 8'(col);
        return {rw, a};
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        fifo_empty = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic expect_ev(input int c, input int cy);
        exp_cmd.push_back(c);
        exp_cyc.push_back(cy);
    endtask

    // Feeds the request queue as a FIFO head, logs every non-NOP command with its cycle.
    task automatic run_reqs(input string tag);
        int cyc;
        ev_cmd.delete();
        ev_cyc.delete();
        ev_pop.delete();
        n_pops = 0;
        cyc = 0;
        while (req_q.size() > 0 && cyc < 400) begin
            fifo_empty = 1'b0;
            address = req_q[0][31:0];
            r_w = req_q[0][32];
            write_data = 32'hA5A5_0000 + 32'(cyc);
            @(negedge clk);
            if (command != 3'd0) begin
                ev_cmd.push_back(int'(command));
                ev_cyc.push_back(cyc);
                ev_pop.push_back(int'(pop));
            end
            if (pop) begin
                n_pops++;
                void'(req_q.pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        fifo_empty = 1'b1;
        check_val({tag, "_drained"}, 32'(req_q.size()), 32'd0);
        req_q.delete();
    endtask

    task automatic compare_events(input string tag);
        check_val({tag, "_nevents"}, 32'(ev_cmd.size()), 32'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size() && i < ev_cmd.size(); i++) begin
            check_val($sformatf("%s_cmd%0d", tag, i), 32'(ev_cmd[i]), 32'(exp_cmd[i]));
            check_val($sformatf("%s_cyc%0d", tag, i), 32'(ev_cyc[i]), 32'(exp_cyc[i]));
            check_val($sformatf("%s_pop%0d", tag, i), 32'(ev_pop[i]),
                      32'((exp_cmd[i] == RD || exp_cmd[i] == WR) ? 1 : 0));
        end
        exp_cmd.delete();
        exp_cyc.delete();
    endtask

    initial begin
        // Reset held with a valid head: never a command, never a pop.
        reset = 1'b1;
        fifo_empty = 1'b0;
        address = mk(0, 0, 'h200, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val($sformatf("rst_cmd%0d", i), 32'(command), 32'(NOP));
            check_val($sformatf("rst_pop%0d", i), 32'(pop), 32'd0);
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        fifo_empty = 1'b1;

        // Row hits: one ACT then reads spaced by tCCD_L.
        do_reset(2);
        req_q.push_back(mk(0, 0, 'h200, 'h00, 1'b0));
        req_q.push_back(mk(0, 0, 'h200, 'h08, 1'b0));
        req_q.push_back(mk(0, 0, 'h200, 'h10, 1'b0));
        run_reqs("hit");
        expect_ev(ACT, 0); expect_ev(RD, 14); expect_ev(RD, 20); expect_ev(RD, 26);
        compare_events("hit");
        check_val("hit_pops", 32'(n_pops), 32'd3);

        // Mid-operation reset: bank 0 is open on row 0x200; reset must forget it.
        fifo_empty = 1'b0;
        address = mk(0, 0, 'h200, 'h18, 1'b0);
        r_w = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_cmd", 32'(command), 32'(NOP));
        check_val("midrst_pop", 32'(pop), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("postrst_cmd", 32'(command), 32'(ACT));
        check_val("postrst_pop", 32'(pop), 32'd0);
        fifo_empty = 1'b1;

        // Row conflict: PRE bounded by tRAS, then tRP, then tRCD.
        do_reset(2);
        req_q.push_back(mk(0, 0, 'hA, 0, 1'b0));
        req_q.push_back(mk(0, 0, 'hB, 0, 1'b0));
        run_reqs("conf");
        expect_ev(ACT, 0); expect_ev(RD, 14); expect_ev(PRE, 32); expect_ev(ACT, 46); expect_ev(RD, 60);
        compare_events("conf");

        // Multi-bank: same-BG and cross-BG spacing.
        do_reset(2);
        req_q.push_back(mk(0, 0, 'h64, 0, 1'b0));
        req_q.push_back(mk(0, 1, 'hC8, 0, 1'b0));
        req_q.push_back(mk(0, 0, 'h64, 8, 1'b0));
        req_q.push_back(mk(1, 0, 'h12C, 0, 1'b0));
        run_reqs("multi");
        expect_ev(ACT, 0); expect_ev(RD, 14); expect_ev(ACT, 15); expect_ev(RD, 29);
        expect_ev(RD, 35); expect_ev(ACT, 36); expect_ev(RD, 50);
        compare_events("multi");

        // Write then read same row (tWTR after write data), then a conflicting row (write recovery).
        do_reset(2);
        req_q.push_back(mk(0, 0, 'h10, 0, 1'b1));
        req_q.push_back(mk(0, 0, 'h10, 8, 1'b0));
        req_q.push_back(mk(0, 0, 'h11, 0, 1'b0));
        run_reqs("wtr");
        expect_ev(ACT, 0); expect_ev(WR, 14); expect_ev(RD, 36);
        expect_ev(PRE, 46); expect_ev(ACT, 60); expect_ev(RD, 74);
        compare_events("wtr");

        // Ping-pong rows: every request after the first needs PRE, ACT, RD.
        do_reset(2);
        for (int k = 0; k < 4; k++) req_q.push_back(mk(0, 0, (k % 2 == 0) ? 'hA : 'hB, 0, 1'b0));
        run_reqs("ping");
        expect_ev(ACT, 0); expect_ev(RD, 14);
        for (int k = 1; k < 4; k++) begin
            expect_ev(PRE, 32 + 46 * (k - 1));
            expect_ev(ACT, 46 + 46 * (k - 1));
            expect_ev(RD, 60 + 46 * (k - 1));
        end
        compare_events("ping");
        check_val("ping_pops", 32'(n_pops), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
